io_tx_buffer: RTL



---
 rtl/io_tx_buffer.sv | 81 ++++++++
 1 files changed

// File: rtl/io_tx_buffer.sv
// io_tx_buffer: snoops CPU I/O-port writes into a FWFT FIFO drained to the UART, with back-pressure and stop/halt.
//   clk_in, rst_in (async active-low)          clock and reset
//   rdy_in, mem_a, mem_dout, mem_wr            snooped CPU memory bus
//   io_buffer_full                             back-pressure to CPU
//   tx_data, tx_valid, tx_ready                UART valid/ready handshake
//   count, overflow, halt                      occupancy, sticky drop flag, sticky halt
module io_tx_buffer #(
    parameter int DEPTH       = 16,
    parameter int PTR_W       = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic [31:0]      mem_a,
    input  logic [7:0]       mem_dout,
    input  logic             mem_wr,
    output logic             io_buffer_full,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             halt
);
    typedef enum logic [1:0] {IDLE, DRAIN, HALTED} state_t;

    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] FULL_AT = (PTR_W+1)'(DEPTH - FULL_MARGIN);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    state_t           state, state_nxt;
    logic             io_sel, uart_wr, stop_wr, stop_pending, push_req, push, pop, full;
    logic             unused_addr;

    assign unused_addr  = ^{mem_a[31:18], mem_a[15:3]};
    assign io_sel       = mem_a[17:16] == 2'b11;
    assign uart_wr      = rdy_in & mem_wr & io_sel & (mem_a[2:0] == 3'b000);
    assign stop_wr      = rdy_in & mem_wr & io_sel & (mem_a[2:0] == 3'b100);
    assign stop_pending = state != IDLE;
    assign halt         = state == HALTED;
    assign full         = count == CNT_MAX;
    assign pop          = tx_valid & tx_ready;
    assign push_req     = uart_wr & (mem_dout != 8'h00) & ~stop_pending;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push         = push_req & (~full | pop);
    assign tx_valid     = count != '0;
    assign tx_data      = mem[rd_ptr];
    // thresholding on count is equivalent to (DEPTH - count) <= FULL_MARGIN
    assign io_buffer_full = count >= FULL_AT;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = stop_wr ? DRAIN : IDLE;
            DRAIN:   state_nxt = (count == '0 && !push) ? HALTED : DRAIN;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_ptr   <= rd_ptr + PTR_W'(pop);
            wr_ptr   <= wr_ptr + PTR_W'(push);
            count    <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            overflow <= overflow | (push_req & full & ~pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= mem_dout;
    end
endmodule
